// File: rtl/serial_add_ctrl_if.sv
// Start/done handshake and operand/result bus of the bit-serial adder controller.
//   start, a, b, cin : request side, driven by the requester (master)
//   busy, done       : controller status, done is a one-cycle result-valid pulse
//   sum, cout        : result, held until the next accepted start
interface serial_add_ctrl_if #(
  parameter int unsigned WIDTH = 8
) ();

  logic             start;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             cin;
  logic             busy;
  logic             done;
  logic [WIDTH-1:0] sum;
  logic             cout;

  modport master (
    output start, a, b, cin,
    input  busy, done, sum, cout
  );

  modport slave (
    input  start, a, b, cin,
    output busy, done, sum, cout
  );

endinterface

// File: rtl/serial_add_ctrl.sv
// Bit-serial adder controller: adds two WIDTH-bit operands LSB first, one bit per
// clock, through an external combinational 1-bit full adder.
//   clk, rst            : clock (rising edge), asynchronous active-high reset
//   bus (slave)         : start/a/b/cin request, busy/done/sum/cout result
//   fa_a, fa_b, fa_c0   : operand bits and carry presented to the full adder
//   fa_s, fa_c1         : sum and carry-out returned by the full adder
module serial_add_ctrl #(
  parameter int unsigned WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  serial_add_ctrl_if.slave bus,
  output logic             fa_a,
  output logic             fa_b,
  output logic             fa_c0,
  input  logic             fa_s,
  input  logic             fa_c1
);

  localparam int unsigned CNT_W = $clog2(WIDTH) + 1;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_DONE = 2'd2
  } state_t;

  state_t           state_q, state_d;
  logic [WIDTH-1:0] a_sh_q, a_sh_d;
  logic [WIDTH-1:0] b_sh_q, b_sh_d;
  logic [WIDTH-1:0] sum_q, sum_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             carry_q, carry_d;
  logic             cout_q, cout_d;
  logic             busy_q, busy_d;
  logic             done_q, done_d;

  // Next-state and datapath update
  always_comb begin
    state_d = state_q;
    a_sh_d  = a_sh_q;
    b_sh_d  = b_sh_q;
    sum_d   = sum_q;
    cnt_d   = cnt_q;
    carry_d = carry_q;
    cout_d  = cout_q;
    busy_d  = busy_q;
    done_d  = 1'b0;

    case (state_q)
      S_IDLE: begin
        if (bus.start) begin
          a_sh_d  = bus.a;
          b_sh_d  = bus.b;
          carry_d = bus.cin;
          cnt_d   = '0;
          sum_d   = '0;
          cout_d  = 1'b0;
          busy_d  = 1'b1;
          state_d = S_RUN;
        end
      end

      S_RUN: begin
        // New sum bit enters at the MSB so the LSB lands at bit 0 after WIDTH shifts
        sum_d   = (sum_q >> 1) | (WIDTH'(fa_s) << (WIDTH - 1));
        carry_d = fa_c1;
        a_sh_d  = a_sh_q >> 1;
        b_sh_d  = b_sh_q >> 1;
        cnt_d   = cnt_q + CNT_W'(1);
        if (cnt_q == CNT_W'(WIDTH - 1)) begin
          cout_d  = fa_c1;
          done_d  = 1'b1;
          state_d = S_DONE;
        end
      end

      S_DONE: begin
        busy_d  = 1'b0;
        state_d = S_IDLE;
      end

      default: begin
        busy_d  = 1'b0;
        state_d = S_IDLE;
      end
    endcase
  end

  // State and output registers
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= S_IDLE;
      a_sh_q  <= '0;
      b_sh_q  <= '0;
      sum_q   <= '0;
      cnt_q   <= '0;
      carry_q <= 1'b0;
      cout_q  <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      a_sh_q  <= a_sh_d;
      b_sh_q  <= b_sh_d;
      sum_q   <= sum_d;
      cnt_q   <= cnt_d;
      carry_q <= carry_d;
      cout_q  <= cout_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
    end
  end

  // Full-adder inputs come straight from flops and are gated to 0 outside RUN
  assign fa_a  = (state_q == S_RUN) & a_sh_q[0];
  assign fa_b  = (state_q == S_RUN) & b_sh_q[0];
  assign fa_c0 = (state_q == S_RUN) & carry_q;

  assign bus.busy = busy_q;
  assign bus.done = done_q;
  assign bus.sum  = sum_q;
  assign bus.cout = cout_q;

endmodule

// File: tb/tb_serial_add_ctrl.sv
// Self-checking bench for serial_add_ctrl with a behavioural full adder alongside.
module tb_serial_add_ctrl;

  localparam int unsigned WIDTH = 8;

  logic clk = 1'b0;
  logic rst;
  logic fa_a, fa_b, fa_c0, fa_s, fa_c1;

  always #5 clk = ~clk;

  serial_add_ctrl_if #(.WIDTH(WIDTH)) bus ();

  // Purely combinational 1-bit full adder
  assign fa_s  = fa_a ^ fa_b ^ fa_c0;
  assign fa_c1 = (fa_a & fa_b) | (fa_c0 & (fa_a ^ fa_b));

  serial_add_ctrl #(.WIDTH(WIDTH)) dut (
    .clk   (clk),
    .rst   (rst),
    .bus   (bus.slave),
    .fa_a  (fa_a),
    .fa_b  (fa_b),
    .fa_c0 (fa_c0),
    .fa_s  (fa_s),
    .fa_c1 (fa_c1)
  );

  typedef struct {
    logic [7:0] a;
    logic [7:0] b;
    logic       cin;
    logic [7:0] sum;
    logic       cout;
  } vec_t;

  vec_t vecs [8];

  int n_checks = 0;
  int n_fail   = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Reference result from plain arithmetic
  function automatic logic [8:0] ref_add(input logic [7:0] a, input logic [7:0] b, input logic cin);
    return 9'(a) + 9'(b) + 9'(cin);
  endfunction

  // One complete add with latency, busy, first-cycle full-adder inputs and result checks
  task automatic do_add(input logic [7:0] a, input logic [7:0] b, input logic cin,
                        input logic [8:0] exp);
    int lat;
    int busy_low;
    @(negedge clk);
    bus.a     = a;
    bus.b     = b;
    bus.cin   = cin;
    bus.start = 1'b1;
    @(negedge clk);
    bus.start = 1'b0;
    check("busy_first_run", 32'(bus.busy), 32'(1));
    check("done_first_run", 32'(bus.done), 32'(0));
    check("fa_a_first_run", 32'(fa_a), 32'(a[0]));
    check("fa_b_first_run", 32'(fa_b), 32'(b[0]));
    check("fa_c0_first_run", 32'(fa_c0), 32'(cin));
    lat      = 0;
    busy_low = 0;
    for (int k = 1; k <= 20; k++) begin
      @(negedge clk);
      if (!bus.busy) busy_low++;
      if (bus.done) begin
        lat = k;
        break;
      end
    end
    check("done_latency", 32'(lat), 32'(WIDTH));
    check("busy_low_cycles", 32'(busy_low), 32'(0));
    check("sum", 32'(bus.sum), 32'(exp[7:0]));
    check("cout", 32'(bus.cout), 32'(exp[8]));
    @(negedge clk);
    check("done_one_cycle", 32'(bus.done), 32'(0));
    check("busy_after_done", 32'(bus.busy), 32'(0));
    check("sum_held", 32'({bus.cout, bus.sum}), 32'(exp));
  endtask

  initial begin
    int         pulses;
    int         last_done;
    logic [8:0] expq [$];
    logic [8:0] e;
    logic [7:0] ra, rb;
    logic       rc;

    vecs[0] = '{a: 8'h35, b: 8'h4A, cin: 1'b0, sum: 8'h7F, cout: 1'b0};
    vecs[1] = '{a: 8'hFF, b: 8'h01, cin: 1'b0, sum: 8'h00, cout: 1'b1};
    vecs[2] = '{a: 8'hFF, b: 8'hFF, cin: 1'b1, sum: 8'hFF, cout: 1'b1};
    vecs[3] = '{a: 8'h80, b: 8'h80, cin: 1'b0, sum: 8'h00, cout: 1'b1};
    vecs[4] = '{a: 8'h00, b: 8'h00, cin: 1'b1, sum: 8'h01, cout: 1'b0};
    vecs[5] = '{a: 8'h0F, b: 8'hF0, cin: 1'b1, sum: 8'h00, cout: 1'b1};
    vecs[6] = '{a: 8'h00, b: 8'h00, cin: 1'b0, sum: 8'h00, cout: 1'b0};
    vecs[7] = '{a: 8'hAA, b: 8'h55, cin: 1'b0, sum: 8'hFF, cout: 1'b0};

    rst       = 1'b1;
    bus.start = 1'b0;
    bus.a     = '0;
    bus.b     = '0;
    bus.cin   = 1'b0;
    #1;
    check("rst_busy", 32'(bus.busy), 32'(0));
    check("rst_done", 32'(bus.done), 32'(0));
    check("rst_sum", 32'(bus.sum), 32'(0));
    check("rst_cout", 32'(bus.cout), 32'(0));
    check("rst_fa", 32'({fa_a, fa_b, fa_c0}), 32'(0));
    repeat (3) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    check("idle_busy", 32'(bus.busy), 32'(0));

    // Directed vectors
    for (int i = 0; i < 8; i++)
      do_add(vecs[i].a, vecs[i].b, vecs[i].cin, {vecs[i].cout, vecs[i].sum});

    // Start while busy is ignored and not queued
    @(negedge clk);
    bus.a = 8'h10; bus.b = 8'h20; bus.cin = 1'b0; bus.start = 1'b1;
    @(negedge clk);
    bus.start = 1'b0;
    repeat (2) @(negedge clk);
    bus.a = 8'hFF; bus.start = 1'b1;
    @(negedge clk);
    bus.start = 1'b0;
    pulses = 0;
    for (int k = 0; k < 15; k++) begin
      @(negedge clk);
      if (bus.done) begin
        pulses++;
        check("ignored_start_sum", 32'({bus.cout, bus.sum}), 32'(9'h030));
      end
    end
    check("ignored_start_pulses", 32'(pulses), 32'(1));
    check("ignored_start_idle", 32'(bus.busy), 32'(0));

    // Reset in the middle of RUN aborts without a done pulse
    @(negedge clk);
    bus.a = 8'hAA; bus.b = 8'h55; bus.cin = 1'b0; bus.start = 1'b1;
    @(negedge clk);
    bus.start = 1'b0;
    repeat (3) @(negedge clk);
    rst = 1'b1;
    #1;
    check("midrun_rst_busy", 32'(bus.busy), 32'(0));
    check("midrun_rst_done", 32'(bus.done), 32'(0));
    check("midrun_rst_sum", 32'(bus.sum), 32'(0));
    check("midrun_rst_cout", 32'(bus.cout), 32'(0));
    check("midrun_rst_fa", 32'({fa_a, fa_b, fa_c0}), 32'(0));
    @(posedge clk);
    @(negedge clk);
    rst    = 1'b0;
    pulses = 0;
    for (int k = 0; k < 12; k++) begin
      @(negedge clk);
      if (bus.done) pulses++;
    end
    check("midrun_rst_no_done", 32'(pulses), 32'(0));
    do_add(8'h01, 8'h01, 1'b0, 9'h002);

    // Randomized adds against the arithmetic reference
    for (int i = 0; i < 30; i++) begin
      ra = 8'($urandom);
      rb = 8'($urandom);
      rc = 1'($urandom);
      do_add(ra, rb, rc, ref_add(ra, rb, rc));
    end

    // Start held high: one add every WIDTH+2 cycles, new operands per add
    @(negedge clk);
    bus.a = 8'h12; bus.b = 8'h34; bus.cin = 1'b1;
    expq.push_back(ref_add(8'h12, 8'h34, 1'b1));
    bus.start = 1'b1;
    pulses    = 0;
    last_done = -1;
    for (int cyc = 0; cyc < 61; cyc++) begin
      @(negedge clk);
      if (bus.done) begin
        e = (expq.size() > 0) ? expq.pop_front() : 9'h000;
        check("b2b_result", 32'({bus.cout, bus.sum}), 32'(e));
        if (pulses > 0) check("b2b_spacing", 32'(cyc - last_done), 32'(WIDTH + 2));
        last_done = cyc;
        pulses++;
        ra = 8'($urandom);
        rb = 8'($urandom);
        rc = 1'($urandom);
        bus.a   = ra;
        bus.b   = rb;
        bus.cin = rc;
        expq.push_back(ref_add(ra, rb, rc));
      end
    end
    bus.start = 1'b0;
    check("b2b_pulses", 32'(pulses), 32'(6));
    repeat (12) @(negedge clk);
    check("final_idle", 32'(bus.busy), 32'(0));

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog timeout");
  end

endmodule
